// File: rtl/ifetch.sv
// ifetch: instruction fetch stage feeding dec.
//
// Keeps the fetch PC and issues word requests on a req/gnt + rvalid
// instruction-memory interface. Returned words are buffered in a small FIFO.
// A registered {instr, pc} pair is presented to dec every cycle. A NOP bubble
// is inserted when the buffer is empty or a redirect happens.
//
// Credit scheme: requests in flight plus buffered entries never exceed
// FIFO_DEPTH. As a result, a response always finds room and rvalid needs no
// backpressure.
//
// On a redirect from exe the buffer is flushed. Responses still in flight are
// counted in dropCnt_q and discarded as they return.
//
// Ports:
//   clk, reset           clock, asynchronous active-high reset
//   imem_req_o           fetch request valid
//   imem_adr_o           fetch address (word aligned)
//   imem_gnt_i           request accepted this cycle
//   imem_rvalid_i        in-order response valid
//   imem_rdata_i         instruction word
//   branch_v_i           redirect/flush from exe
//   branch_target_i      redirect address
//   stall_i              hold the output register
//   instr_q_o            instruction to dec
//   pc0_q_o              PC of instr_q_o
//   instr_v_q_o          instr_q_o is a real fetched instruction
//   instr_misaligned_q_o (only with IFETCH_MISALIGN_EXC_EN) misaligned target
//
// Optional feature macro: IFETCH_MISALIGN_EXC_EN.
//   Defined:   a redirect to a misaligned target issues no fetch. Instead it
//              reports an instr_misaligned_q_o marker and halts fetch until
//              the next redirect.
//   Undefined: the low two bits of the target are forced to zero.

module ifetch #(
    parameter int              XLEN            = 32,
    parameter logic [XLEN-1:0] RESET_PC        = 32'h8000_0000,
    parameter int              FIFO_DEPTH      = 2,
    parameter int              MAX_OUTSTANDING = 2
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_adr_o,
    input  logic            imem_gnt_i,
    input  logic            imem_rvalid_i,
    input  logic [XLEN-1:0] imem_rdata_i,
    input  logic            branch_v_i,
    input  logic [XLEN-1:0] branch_target_i,
    input  logic            stall_i,
    output logic [XLEN-1:0] instr_q_o,
    output logic [XLEN-1:0] pc0_q_o,
    output logic            instr_v_q_o
`ifdef IFETCH_MISALIGN_EXC_EN
    ,
    output logic            instr_misaligned_q_o
`endif
);

    localparam int CNT_W  = $clog2(FIFO_DEPTH + MAX_OUTSTANDING + 1);
    localparam int FPTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int PPTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam logic [CNT_W-1:0] FIFO_DEPTH_C = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] MAX_OUT_C    = CNT_W'(MAX_OUTSTANDING);
    localparam logic [XLEN-1:0]  NOP_INSTR    = XLEN'(32'h0000_0013);

    logic [XLEN-1:0]   fetchPc_q, fetchPc_d;
    logic [CNT_W-1:0]  outstanding_q, outstanding_d;
    logic [CNT_W-1:0]  dropCnt_q, dropCnt_d;
    logic [CNT_W-1:0]  fifoCount_q, fifoCount_d;
    logic [FPTR_W-1:0] fifoWr_q, fifoWr_d, fifoRd_q, fifoRd_d;
    logic [PPTR_W-1:0] pendWr_q, pendWr_d, pendRd_q, pendRd_d;
    logic [XLEN-1:0]   fifoPc_q    [FIFO_DEPTH];
    logic [XLEN-1:0]   fifoInstr_q [FIFO_DEPTH];
    logic [XLEN-1:0]   pendPc_q    [MAX_OUTSTANDING];
    logic [XLEN-1:0]   instr_q, instr_d, pc0_q, pc0_d;
    logic              instrV_q, instrV_d;

    logic              rspValid, reqFire, fifoPush, fifoPop;
    logic [CNT_W-1:0]  reqInc, rspDec, pushInc, popDec;
    logic [XLEN-1:0]   branchTarget;
    logic              misalignRedirect, fetchHalt;

    function automatic logic [FPTR_W-1:0] fifoInc(input logic [FPTR_W-1:0] p);
        return (p == FPTR_W'(FIFO_DEPTH - 1)) ? '0 : p + FPTR_W'(1);
    endfunction

    function automatic logic [PPTR_W-1:0] pendInc(input logic [PPTR_W-1:0] p);
        return (p == PPTR_W'(MAX_OUTSTANDING - 1)) ? '0 : p + PPTR_W'(1);
    endfunction

`ifdef IFETCH_MISALIGN_EXC_EN
    logic halt_q, halt_d, misaligned_q, misaligned_d;

    assign branchTarget     = branch_target_i;
    assign misalignRedirect = branch_v_i & (branch_target_i[1:0] != 2'b00);
    assign fetchHalt        = halt_q;

    // Fetch halts on a misaligned redirect until the next redirect. The
    // marker follows the output register: it is held under stall and cleared
    // on any other load.
    always_comb begin
        halt_d       = halt_q;
        misaligned_d = misaligned_q;
        if (branch_v_i) begin
            halt_d       = misalignRedirect;
            misaligned_d = misalignRedirect;
        end else if (!stall_i) begin
            misaligned_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            halt_q       <= 1'b0;
            misaligned_q <= 1'b0;
        end else begin
            halt_q       <= halt_d;
            misaligned_q <= misaligned_d;
        end
    end

    assign instr_misaligned_q_o = misaligned_q;
`else
    logic unused_targetLsbs;

    assign branchTarget      = {branch_target_i[XLEN-1:2], 2'b00};
    assign misalignRedirect  = 1'b0;
    assign fetchHalt         = 1'b0;
    assign unused_targetLsbs = ^branch_target_i[1:0];
`endif

    // A response with nothing outstanding is spurious and is ignored.
    assign rspValid = imem_rvalid_i & (outstanding_q != '0);
    assign reqFire  = imem_req_o & imem_gnt_i;
    assign fifoPush = rspValid & (dropCnt_q == '0) & ~branch_v_i;
    assign fifoPop  = ~branch_v_i & ~stall_i & (fifoCount_q != '0);
    assign reqInc   = {{(CNT_W-1){1'b0}}, reqFire};
    assign rspDec   = {{(CNT_W-1){1'b0}}, rspValid};
    assign pushInc  = {{(CNT_W-1){1'b0}}, fifoPush};
    assign popDec   = {{(CNT_W-1){1'b0}}, fifoPop};

    assign imem_req_o = ~reset & ~branch_v_i & ~fetchHalt
                      & (outstanding_q < MAX_OUT_C)
                      & ((outstanding_q + fifoCount_q) < FIFO_DEPTH_C);
    assign imem_adr_o = fetchPc_q;

    // Fetch PC, in-flight bookkeeping and buffer pointers. A redirect clears
    // the buffer but leaves the pending-PC queue alone. The queue still has to
    // pair up with the responses that are about to be dropped.
    always_comb begin
        fetchPc_d     = reqFire ? fetchPc_q + XLEN'(4) : fetchPc_q;
        outstanding_d = outstanding_q + reqInc - rspDec;
        pendWr_d      = reqFire  ? pendInc(pendWr_q) : pendWr_q;
        pendRd_d      = rspValid ? pendInc(pendRd_q) : pendRd_q;
        dropCnt_d     = dropCnt_q;
        fifoWr_d      = fifoPush ? fifoInc(fifoWr_q) : fifoWr_q;
        fifoRd_d      = fifoPop  ? fifoInc(fifoRd_q) : fifoRd_q;
        fifoCount_d   = fifoCount_q + pushInc - popDec;
        if (rspValid && (dropCnt_q != '0)) begin
            dropCnt_d = dropCnt_q - CNT_W'(1);
        end
        if (branch_v_i) begin
            fetchPc_d   = branchTarget;
            dropCnt_d   = outstanding_q - rspDec;
            fifoWr_d    = '0;
            fifoRd_d    = '0;
            fifoCount_d = '0;
        end
    end

    // Output register priority: redirect, then stall, then buffer, then
    // bubble. During a bubble pc0 keeps its last value.
    always_comb begin
        instr_d  = instr_q;
        pc0_d    = pc0_q;
        instrV_d = instrV_q;
        if (branch_v_i) begin
            instr_d  = NOP_INSTR;
            instrV_d = misalignRedirect;
            if (misalignRedirect) begin
                pc0_d = branchTarget;
            end
        end else if (!stall_i) begin
            if (fifoPop) begin
                instr_d  = fifoInstr_q[fifoRd_q];
                pc0_d    = fifoPc_q[fifoRd_q];
                instrV_d = 1'b1;
            end else begin
                instr_d  = NOP_INSTR;
                instrV_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetchPc_q     <= RESET_PC;
            outstanding_q <= '0;
            dropCnt_q     <= '0;
            fifoCount_q   <= '0;
            fifoWr_q      <= '0;
            fifoRd_q      <= '0;
            pendWr_q      <= '0;
            pendRd_q      <= '0;
            instr_q       <= NOP_INSTR;
            pc0_q         <= '0;
            instrV_q      <= 1'b0;
        end else begin
            fetchPc_q     <= fetchPc_d;
            outstanding_q <= outstanding_d;
            dropCnt_q     <= dropCnt_d;
            fifoCount_q   <= fifoCount_d;
            fifoWr_q      <= fifoWr_d;
            fifoRd_q      <= fifoRd_d;
            pendWr_q      <= pendWr_d;
            pendRd_q      <= pendRd_d;
            instr_q       <= instr_d;
            pc0_q         <= pc0_d;
            instrV_q      <= instrV_d;
        end
    end

    // Data storage needs no reset; the valid state lives in the counters.
    // Push and pop of the pending queue never hit the same slot in one cycle.
    always_ff @(posedge clk) begin
        if (reqFire) begin
            pendPc_q[pendWr_q] <= fetchPc_q;
        end
        if (fifoPush) begin
            fifoPc_q[fifoWr_q]    <= pendPc_q[pendRd_q];
            fifoInstr_q[fifoWr_q] <= imem_rdata_i;
        end
    end

    assign instr_q_o   = instr_q;
    assign pc0_q_o     = pc0_q;
    assign instr_v_q_o = instrV_q;

endmodule

// File: tb/tb_ifetch.sv
// tb_ifetch: self-checking bench for ifetch.
// The memory model answers each granted request one cycle later, in order.
// Each granted address is pushed onto a scoreboard queue. A redirect clears
// the queue. Every valid instruction seen by dec pops the queue and is
// compared against it.

module tb_ifetch;

    localparam logic [31:0] RESET_PC = 32'h8000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req_o;
    logic [31:0] imem_adr_o;
    logic        imem_gnt_i = 1'b0;
    logic        imem_rvalid_i = 1'b0;
    logic [31:0] imem_rdata_i = 32'h0;
    logic        branch_v_i = 1'b0;
    logic [31:0] branch_target_i = 32'h0;
    logic        stall_i = 1'b0;
    logic [31:0] instr_q_o;
    logic [31:0] pc0_q_o;
    logic        instr_v_q_o;
`ifdef IFETCH_MISALIGN_EXC_EN
    logic        instr_misaligned_q_o;
`endif

    int          compared = 0;
    int          mismatched = 0;
    logic [31:0] memQ[$];
    logic [31:0] expQ[$];
    logic [31:0] expAdr = RESET_PC;
    int          cycle = 0;
    int          firstLoadCycle = -1;
    bit          memHold = 1'b0;
    bit          spuriousRsp = 1'b0;
    bit          lastReq = 1'b0;

    always #5 clk = ~clk;

    ifetch dut (
        .clk             (clk),
        .reset           (reset),
        .imem_req_o      (imem_req_o),
        .imem_adr_o      (imem_adr_o),
        .imem_gnt_i      (imem_gnt_i),
        .imem_rvalid_i   (imem_rvalid_i),
        .imem_rdata_i    (imem_rdata_i),
        .branch_v_i      (branch_v_i),
        .branch_target_i (branch_target_i),
        .stall_i         (stall_i),
        .instr_q_o       (instr_q_o),
        .pc0_q_o         (pc0_q_o),
        .instr_v_q_o     (instr_v_q_o)
`ifdef IFETCH_MISALIGN_EXC_EN
        ,
        .instr_misaligned_q_o (instr_misaligned_q_o)
`endif
    );

    function automatic logic [31:0] memData(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC0DE_F00D;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cycle);
        end
    endtask

    // One clock cycle: drive inputs just after the edge and check the request
    // mid-cycle. Then update the models at the edge and check the output
    // register just after it.
    task automatic applyStimulus(input bit gnt, input bit br, input logic [31:0] tgt, input bit stl);
        bit          fromMem;
        bit          expMis;
        logic [31:0] prevInstr, prevPc, e;
        logic        prevV;
        fromMem = 1'b0;
        expMis  = 1'b0;
        imem_gnt_i      = gnt;
        branch_v_i      = br;
        branch_target_i = tgt;
        stall_i         = stl;
        if (spuriousRsp) begin
            imem_rvalid_i = 1'b1;
            imem_rdata_i  = 32'hDEAD_BEEF;
            spuriousRsp   = 1'b0;
        end else if (!memHold && memQ.size() > 0) begin
            imem_rvalid_i = 1'b1;
            imem_rdata_i  = memData(memQ[0]);
            fromMem       = 1'b1;
        end else begin
            imem_rvalid_i = 1'b0;
            imem_rdata_i  = 32'h0;
        end
        prevInstr = instr_q_o;
        prevPc    = pc0_q_o;
        prevV     = instr_v_q_o;
        #3;
        lastReq = imem_req_o;
        if (imem_req_o) checkOutput("fetchAdr", imem_adr_o, expAdr);
        if (br) checkOutput("reqOnBranch", 32'(imem_req_o), 32'd0);
        if (imem_req_o && gnt) begin
            memQ.push_back(imem_adr_o);
            expQ.push_back(imem_adr_o);
            expAdr = imem_adr_o + 32'd4;
        end
        @(posedge clk);
        if (fromMem) void'(memQ.pop_front());
        if (br) begin
            expQ.delete();
`ifdef IFETCH_MISALIGN_EXC_EN
            expAdr = tgt;
`else
            expAdr = tgt & ~32'h3;
`endif
        end
        cycle++;
        #1;
        if (br) begin
`ifdef IFETCH_MISALIGN_EXC_EN
            expMis = (tgt[1:0] != 2'b00);
            checkOutput("branchMisFlag", 32'(instr_misaligned_q_o), 32'(expMis));
`endif
            checkOutput("branchV", 32'(instr_v_q_o), 32'(expMis));
            checkOutput("branchInstr", instr_q_o, NOP);
            if (expMis) checkOutput("branchMisPc", pc0_q_o, tgt);
        end else if (stl) begin
            checkOutput("stallInstr", instr_q_o, prevInstr);
            checkOutput("stallPc", pc0_q_o, prevPc);
            checkOutput("stallV", 32'(instr_v_q_o), 32'(prevV));
        end else begin
`ifdef IFETCH_MISALIGN_EXC_EN
            checkOutput("misFlagClear", 32'(instr_misaligned_q_o), 32'd0);
`endif
            if (instr_v_q_o) begin
                if (firstLoadCycle < 0) firstLoadCycle = cycle;
                if (expQ.size() == 0) begin
                    checkOutput("unexpectedValid", 32'(instr_v_q_o), 32'd0);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("pc0", pc0_q_o, e);
                    checkOutput("instr", instr_q_o, memData(e));
                end
            end else begin
                checkOutput("bubbleInstr", instr_q_o, NOP);
                checkOutput("bubblePc", pc0_q_o, prevPc);
            end
        end
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "Req"}, 32'(imem_req_o), 32'd0);
        checkOutput({tag, "Instr"}, instr_q_o, NOP);
        checkOutput({tag, "Pc"}, pc0_q_o, 32'h0);
        checkOutput({tag, "V"}, 32'(instr_v_q_o), 32'd0);
`ifdef IFETCH_MISALIGN_EXC_EN
        checkOutput({tag, "Mis"}, 32'(instr_misaligned_q_o), 32'd0);
`endif
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Reset values, then streaming with first valid load at cycle 3.
        repeat (3) @(posedge clk);
        #1;
        checkResetState("rst");
        reset = 1'b0;
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
        checkOutput("reqAfterReset", 32'(lastReq), 32'd1);
        repeat (9) applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
        checkOutput("firstValidCycle", 32'(firstLoadCycle), 32'd3);

        // No grant: address holds, request stays up once credit frees.
        repeat (3) applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
        checkOutput("reqWhileNoGnt", 32'(lastReq), 32'd1);
        repeat (4) applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);

        // Stall while streaming: buffer fills, request drops, nothing lost.
        repeat (4) applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
        checkOutput("reqDropWhenFull", 32'(lastReq), 32'd0);
        repeat (6) applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);

        // Redirect with two responses outstanding.
        repeat (4) applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
        memHold = 1'b1;
        repeat (3) applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
        checkOutput("reqAtMaxOutstanding", 32'(lastReq), 32'd0);
        applyStimulus(1'b1, 1'b1, 32'h8000_0100, 1'b0);
        memHold = 1'b0;
        repeat (8) applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);

        // Redirect together with stall and an arriving response.
        repeat (4) applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
        memHold = 1'b1;
        repeat (2) applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
        memHold = 1'b0;
        applyStimulus(1'b1, 1'b1, 32'h8000_0200, 1'b1);
        repeat (8) applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);

        // Back-to-back redirects: the latest target wins.
        repeat (2) applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
        applyStimulus(1'b1, 1'b1, 32'h8000_0300, 1'b0);
        applyStimulus(1'b1, 1'b1, 32'h8000_0400, 1'b0);
        repeat (8) applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);

`ifdef IFETCH_MISALIGN_EXC_EN
        // Misaligned target: marker, halted fetch, then resume on redirect.
        applyStimulus(1'b1, 1'b1, 32'h8000_0102, 1'b0);
        repeat (3) begin
            applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
            checkOutput("reqHaltedMisaligned", 32'(lastReq), 32'd0);
        end
        applyStimulus(1'b1, 1'b1, 32'h8000_0600, 1'b0);
        repeat (8) applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
`else
        // Target low bits are ignored: fetch resumes at 0x8000_0500.
        applyStimulus(1'b1, 1'b1, 32'h8000_0502, 1'b0);
        repeat (8) applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
`endif

        // Reset mid-operation, then a spurious response with nothing pending.
        repeat (2) applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
        reset = 1'b1;
        imem_gnt_i    = 1'b0;
        imem_rvalid_i = 1'b0;
        branch_v_i    = 1'b0;
        stall_i       = 1'b0;
        #3;
        checkResetState("midRst");
        memQ.delete();
        expQ.delete();
        expAdr = RESET_PC;
        @(posedge clk);
        #1;
        reset = 1'b0;
        spuriousRsp = 1'b1;
        repeat (4) applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
        repeat (8) applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);

        // Drain: every granted instruction must have reached dec.
        repeat (8) applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
        checkOutput("drainLeft", 32'(expQ.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
